// File: rtl/up_sel0628_gen2_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sel0628_gen2_pkg
// Brief    : Opcode, ALU-function and FSM-state encodings for up_sel0628_gen2.
// Revision : 1.0
// ============================================================================
package sel0628_gen2_pkg;

    localparam logic [1:0] OP_LD  = 2'b00;
    localparam logic [1:0] OP_ST  = 2'b01;
    localparam logic [1:0] OP_ALU = 2'b10;
    localparam logic [1:0] OP_JC  = 2'b11;

    localparam logic [1:0] F_ADD  = 2'b00;
    localparam logic [1:0] F_SUB  = 2'b01;
    localparam logic [1:0] F_AND  = 2'b10;
    localparam logic [1:0] F_OR   = 2'b11;

    typedef enum logic [2:0] {
        FETCH    = 3'd0,
        DECODE   = 3'd1,
        EXEC_ALU = 3'd2,
        EXEC_LD  = 3'd3,
        EXEC_ST  = 3'd4,
        EXEC_JC  = 3'd5
    } state_e;

    function automatic state_e exec_state(input logic [1:0] op);
        case (op)
            OP_LD:   return EXEC_LD;
            OP_ST:   return EXEC_ST;
            OP_ALU:  return EXEC_ALU;
            default: return EXEC_JC;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/up_sel0628_gen2_regfile.sv
`default_nettype none
// ============================================================================
// Module   : sel0628_regfile
// Brief    : 2**REG_AW x DATA_W register file, two combinational read ports,
//            one synchronous write port, asynchronous active-high clear.
// Revision : 1.0
// ============================================================================
module sel0628_regfile
    import sel0628_gen2_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int REG_AW = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_we,
    input  logic [REG_AW-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [REG_AW-1:0] i_raddr_a,
    output logic [DATA_W-1:0] o_rdata_a,
    input  logic [REG_AW-1:0] i_raddr_b,
    output logic [DATA_W-1:0] o_rdata_b
);

    localparam int NREG = 1 << REG_AW;

    logic [DATA_W-1:0] r_regs [NREG];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= '0;
            end
        end else if (i_we) begin
            r_regs[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata_a = r_regs[i_raddr_a];
    assign o_rdata_b = r_regs[i_raddr_b];

endmodule
`default_nettype wire

// File: rtl/up_sel0628_gen2.sv
`default_nettype none
// ============================================================================
// Module   : up_sel0628_gen2
// Brief    : Multicycle accumulator/register CPU (LD/ST/ALU/JC) with a
//            req/ack memory port. SEL0628_DBG_TRACE_EN adds trace outputs.
// Revision : 1.0
// ============================================================================
module up_sel0628_gen2
    import sel0628_gen2_pkg::*;
#(
    parameter  int DATA_W = 8,
    parameter  int REG_AW = 2,
    localparam int IW     = 4 + 2 * REG_AW,
    localparam int ADDR_W = IW - 2
) (
    input  logic              clk,
    input  logic              clr,
    output logic              mem_req,
    input  logic              mem_ack,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              flag_z,
    output logic              flag_c
`ifdef SEL0628_DBG_TRACE_EN
    ,
    output logic [ADDR_W-1:0] dbg_pc,
    output logic [IW-1:0]     dbg_ir,
    output logic [2:0]        dbg_state,
    output logic              dbg_retire
`endif
);

    state_e            r_state;
    logic [ADDR_W-1:0] r_pc;
    logic [IW-1:0]     r_ir;
    logic              r_z;
    logic              r_c;

    logic [1:0]        w_op;
    logic [1:0]        w_funct;
    logic [REG_AW-1:0] w_a1;
    logic [REG_AW-1:0] w_a2;
    logic [ADDR_W-1:0] w_addr;
    logic              w_xfer;

    logic [REG_AW-1:0] w_ra_addr;
    logic [DATA_W-1:0] w_ra_data;
    logic [DATA_W-1:0] w_rb_data;
    logic              w_rf_we;
    logic [REG_AW-1:0] w_rf_waddr;
    logic [DATA_W-1:0] w_rf_wdata;

    logic [DATA_W:0]   w_alu_wide;
    logic [DATA_W-1:0] w_alu_res;
    logic              w_alu_c;
    logic              w_alu_z;

    assign w_op    = r_ir[IW-1:IW-2];
    assign w_funct = r_ir[IW-3:IW-4];
    assign w_a1    = r_ir[2*REG_AW-1:REG_AW];
    assign w_a2    = r_ir[REG_AW-1:0];
    assign w_addr  = r_ir[ADDR_W-1:0];

    assign mem_req   = ~clr & ((r_state == FETCH) | (r_state == EXEC_LD) | (r_state == EXEC_ST));
    assign mem_we    = (r_state == EXEC_ST);
    assign mem_addr  = (r_state == FETCH) ? r_pc : w_addr;
    assign w_xfer    = mem_req & mem_ack;

    // Port A serves R[a1] only during EXEC_ALU and R0 otherwise, so it doubles
    // as the store-data path without needing a third read port.
    assign w_ra_addr = (r_state == EXEC_ALU) ? w_a1 : '0;
    assign mem_wdata = w_ra_data;

    always_comb begin
        w_alu_wide = '0;
        case (w_funct)
            F_ADD:   w_alu_wide = {1'b0, w_ra_data} + {1'b0, w_rb_data};
            F_SUB:   w_alu_wide = {1'b0, w_ra_data} - {1'b0, w_rb_data};
            F_AND:   w_alu_wide = {1'b0, w_ra_data & w_rb_data};
            default: w_alu_wide = {1'b0, w_ra_data | w_rb_data};
        endcase
    end

    // The extra top bit is carry-out for ADD and borrow for SUB.
    assign w_alu_res = w_alu_wide[DATA_W-1:0];
    assign w_alu_c   = w_alu_wide[DATA_W];
    assign w_alu_z   = (w_alu_res == '0);

    assign w_rf_we    = (r_state == EXEC_ALU) | ((r_state == EXEC_LD) & w_xfer);
    assign w_rf_waddr = (r_state == EXEC_LD) ? '0 : w_a1;
    assign w_rf_wdata = (r_state == EXEC_LD) ? mem_rdata : w_alu_res;

    sel0628_regfile #(
        .DATA_W (DATA_W),
        .REG_AW (REG_AW)
    ) u_regfile (
        .clk       (clk),
        .rst       (clr),
        .i_we      (w_rf_we),
        .i_waddr   (w_rf_waddr),
        .i_wdata   (w_rf_wdata),
        .i_raddr_a (w_ra_addr),
        .o_rdata_a (w_ra_data),
        .i_raddr_b (w_a2),
        .o_rdata_b (w_rb_data)
    );

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_state <= FETCH;
            r_pc    <= '0;
            r_ir    <= '0;
            r_z     <= 1'b0;
            r_c     <= 1'b0;
        end else begin
            case (r_state)
                FETCH: begin
                    if (w_xfer) begin
                        r_ir    <= mem_rdata[IW-1:0];
                        r_pc    <= r_pc + ADDR_W'(1);
                        r_state <= DECODE;
                    end
                end
                DECODE: begin
                    r_state <= exec_state(w_op);
                end
                EXEC_ALU: begin
                    r_z     <= w_alu_z;
                    r_c     <= (w_funct == F_ADD || w_funct == F_SUB) ? w_alu_c : 1'b0;
                    r_state <= FETCH;
                end
                EXEC_LD, EXEC_ST: begin
                    if (w_xfer) begin
                        r_state <= FETCH;
                    end
                end
                EXEC_JC: begin
                    if (!r_z) begin
                        r_pc <= w_addr;
                    end
                    r_state <= FETCH;
                end
                default: begin
                    r_state <= FETCH;
                end
            endcase
        end
    end

    assign flag_z = r_z;
    assign flag_c = r_c;

`ifdef SEL0628_DBG_TRACE_EN
    assign dbg_pc     = r_pc;
    assign dbg_ir     = r_ir;
    assign dbg_state  = r_state;
    assign dbg_retire = (r_state == EXEC_ALU) | (r_state == EXEC_JC)
                      | (((r_state == EXEC_LD) | (r_state == EXEC_ST)) & w_xfer);
`else
    // Trace outputs are not built in this configuration.
`endif

endmodule
`default_nettype wire
